// File: rtl/bsg_mesh_output_age_sched_pkg.sv
// Shared types and helpers for the mesh output-port age scheduler.
// Holds the FSM state type, the modular timestamp compare and the default starvation limit.
package bsg_mesh_sched_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } sched_state_e;

  localparam int unsigned StarveLimitDefault = 15;

  // a is older than b iff (b - a) mod 2^width is nonzero and below 2^(width-1).
  // A shift by 32 yields 0 in 32 bits, so the mask is all ones for width == 32.
  function automatic logic ts_older(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned width);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << width) - 32'd1;
    diff = (b - a) & mask;
    return (diff != 32'd0) && (diff < (32'd1 << (width - 1)));
  endfunction

endpackage

// File: rtl/bsg_mesh_output_age_sched_if.sv
// Request/grant bundle between the router inputs and one output-port age scheduler.
interface bsg_mesh_output_age_sched_if #(
  parameter int unsigned inputs_p    = 5,
  parameter int unsigned ts_width_p  = 8,
  parameter int unsigned len_width_p = 4
);
  localparam int unsigned IdxW = $clog2(inputs_p);

  logic                              ready_i;
  logic [inputs_p-1:0]               reqs_i;
  logic [inputs_p*ts_width_p-1:0]    ts_i;
  logic [inputs_p*len_width_p-1:0]   len_i;
  logic [inputs_p-1:0]               grants_o;
  logic                              locked_o;
  logic [IdxW-1:0]                   owner_o;
  logic                              starve_o;

  modport master (
    output ready_i, reqs_i, ts_i, len_i,
    input  grants_o, locked_o, owner_o, starve_o
  );

  modport slave (
    input  ready_i, reqs_i, ts_i, len_i,
    output grants_o, locked_o, owner_o, starve_o
  );

endinterface

// File: rtl/bsg_age_sched_oldest.sv
// Combinational oldest-of-N selector; ties among the oldest go to the first index at or
// after rr_ptr_i, cyclically.
module bsg_age_sched_oldest
  import bsg_mesh_sched_pkg::*;
#(
  parameter int unsigned inputs_p   = 5,
  parameter int unsigned ts_width_p = 8,
  parameter int unsigned IdxW       = $clog2(inputs_p)
) (
  input  logic [inputs_p-1:0]            reqs_i,
  input  logic [inputs_p*ts_width_p-1:0] ts_i,
  input  logic [IdxW-1:0]                rr_ptr_i,
  output logic [inputs_p-1:0]            winner_oh_o,
  output logic [IdxW-1:0]                winner_idx_o
);

  logic [inputs_p-1:0] cand;
  logic [inputs_p-1:0] pool;
  logic                found;
  int unsigned         pos;

  // A requester is a candidate when no other requester is strictly older.
  always_comb begin
    cand = reqs_i;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      for (int unsigned j = 0; j < inputs_p; j++) begin
        if (j != i && reqs_i[j] &&
            ts_older(32'(ts_i[j*ts_width_p +: ts_width_p]),
                     32'(ts_i[i*ts_width_p +: ts_width_p]), ts_width_p)) begin
          cand[i] = 1'b0;
        end
      end
    end
  end

  // Only a non-transitive timestamp spread can empty the candidate set; fall back to all.
  assign pool = (cand != '0) ? cand : reqs_i;

  always_comb begin
    found        = 1'b0;
    pos          = 0;
    winner_idx_o = '0;
    winner_oh_o  = '0;
    for (int unsigned k = 0; k < inputs_p; k++) begin
      pos = 32'(rr_ptr_i) + k;
      if (pos >= inputs_p) pos = pos - inputs_p;
      if (!found && pool[pos]) begin
        found        = 1'b1;
        winner_idx_o = IdxW'(pos);
      end
    end
    if (found) winner_oh_o[winner_idx_o] = 1'b1;
  end

endmodule

// File: rtl/bsg_mesh_output_age_sched.sv
// Per-output-port oldest-first scheduler with wormhole locking for the mesh router.
// Optional starvation override is enabled by defining BSG_MESH_AGE_SCHED_STARVE_EN.
module bsg_mesh_output_age_sched
  import bsg_mesh_sched_pkg::*;
#(
  parameter int unsigned inputs_p       = 5,
  parameter int unsigned ts_width_p     = 8,
  parameter int unsigned len_width_p    = 4,
  parameter int unsigned starve_limit_p = StarveLimitDefault
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  bsg_mesh_output_age_sched_if.slave sched
);

  localparam int unsigned IdxW = $clog2(inputs_p);

  sched_state_e           state_q;
  logic [len_width_p-1:0] remaining_q;
  logic [IdxW-1:0]        owner_q;
  logic [IdxW-1:0]        rr_ptr_q;

  logic [inputs_p-1:0]    age_oh;
  logic [IdxW-1:0]        age_idx;
  logic [inputs_p-1:0]    starved;
  logic [IdxW-1:0]        starve_idx;
  logic [inputs_p-1:0]    grants;
  logic [IdxW-1:0]        win_idx;
  logic [len_width_p-1:0] win_len;
  logic                   forced;

  bsg_age_sched_oldest #(
    .inputs_p   (inputs_p),
    .ts_width_p (ts_width_p),
    .IdxW       (IdxW)
  ) u_oldest (
    .reqs_i       (sched.reqs_i),
    .ts_i         (sched.ts_i),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (age_oh),
    .winner_idx_o (age_idx)
  );

`ifdef BSG_MESH_AGE_SCHED_STARVE_EN
  localparam int unsigned CntW = $clog2(starve_limit_p + 1);

  logic [CntW-1:0] wait_q [inputs_p];

  // Descending scan so the lowest starved index wins.
  always_comb begin
    starved    = '0;
    starve_idx = '0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      starved[i] = sched.reqs_i[i] && (wait_q[i] == CntW'(starve_limit_p));
      if (starved[i]) starve_idx = IdxW'(i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < inputs_p; i++) wait_q[i] <= '0;
    end else if (state_q == StIdle && sched.ready_i) begin
      for (int i = 0; i < inputs_p; i++) begin
        if (grants[i]) begin
          wait_q[i] <= '0;
        end else if (sched.reqs_i[i] && wait_q[i] != CntW'(starve_limit_p)) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign starved    = '0;
  assign starve_idx = '0;
`endif

  always_comb begin
    grants  = '0;
    win_idx = age_idx;
    forced  = 1'b0;
    if (!reset_n_i) begin
      grants = '0;
    end else if (state_q == StIdle) begin
      if (sched.ready_i && (sched.reqs_i != '0)) begin
        if (starved != '0) begin
          win_idx             = starve_idx;
          forced              = 1'b1;
          grants[starve_idx]  = 1'b1;
        end else begin
          grants = age_oh;
        end
      end
    end else begin
      // Wormhole: only the owner may move, others are not even evaluated.
      grants[owner_q] = sched.ready_i & sched.reqs_i[owner_q];
    end
  end

  assign win_len = sched.len_i[win_idx*len_width_p +: len_width_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grants != '0) begin
            owner_q  <= win_idx;
            rr_ptr_q <= (win_idx == IdxW'(inputs_p - 1)) ? '0 : win_idx + 1'b1;
            if (win_len != '0) begin
              remaining_q <= win_len;
              state_q     <= StLocked;
            end
          end
        end
        StLocked: begin
          if (grants != '0) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == len_width_p'(1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sched.grants_o = grants;
  assign sched.starve_o = forced;
  assign sched.locked_o = (state_q == StLocked);
  assign sched.owner_o  = owner_q;

endmodule

// File: tb/tb_bsg_mesh_output_age_sched.sv
// Self-checking bench for bsg_mesh_output_age_sched: directed scenarios plus randomized
// traffic against an age-offset reference model.
module tb_bsg_mesh_output_age_sched;

  localparam int N  = 5;
  localparam int TW = 8;
  localparam int LW = 4;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_mesh_output_age_sched_if #(.inputs_p(N), .ts_width_p(TW), .len_width_p(LW)) bus ();

  bsg_mesh_output_age_sched #(
    .inputs_p       (N),
    .ts_width_p     (TW),
    .len_width_p    (LW),
    .starve_limit_p (SL)
  ) u_dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .sched     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus: timestamps are base + offset, so a smaller offset means an older packet.
  int         base;
  int         off [N];
  int         lens [N];
  logic       ready;
  logic [N-1:0] reqs;

  // Reference model state.
  bit m_locked;
  int m_owner, m_rem, m_rr;
  int m_wait [N];

  task automatic apply();
    bus.ready_i = ready;
    bus.reqs_i  = reqs;
    for (int i = 0; i < N; i++) begin
      bus.ts_i[i*TW +: TW]  = TW'(base + off[i]);
      bus.len_i[i*LW +: LW] = LW'(lens[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(output bit forced);
    int best;
    forced = 1'b0;
    if (!rst_n || !ready) return -1;
    if (m_locked) return reqs[m_owner] ? m_owner : -1;
    if (reqs == '0) return -1;
`ifdef BSG_MESH_AGE_SCHED_STARVE_EN
    for (int i = 0; i < N; i++) begin
      if (reqs[i] && m_wait[i] == SL) begin
        forced = 1'b1;
        return i;
      end
    end
`endif
    best = 1 << 30;
    for (int i = 0; i < N; i++) if (reqs[i] && off[i] < best) best = off[i];
    for (int k = 0; k < N; k++) begin
      if (reqs[(m_rr + k) % N] && off[(m_rr + k) % N] == best) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0;
      m_owner  <= 0;
      m_rem    <= 0;
      m_rr     <= 0;
      for (int i = 0; i < N; i++) m_wait[i] <= 0;
    end else begin : upd
      int g;
      bit f;
      g = model_pick(f);
      if (g >= 0) begin
        if (m_locked) begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_locked <= 1'b0;
        end else begin
          m_owner <= g;
          m_rr    <= (g + 1) % N;
          if (lens[g] != 0) begin
            m_locked <= 1'b1;
            m_rem    <= lens[g];
          end
        end
      end
      if (!m_locked && ready) begin
        for (int i = 0; i < N; i++) begin
          if (g == i) m_wait[i] <= 0;
          else if (reqs[i] && m_wait[i] < SL) m_wait[i] <= m_wait[i] + 1;
        end
      end
    end
  end

  task automatic test_reset();
    ready = 1'b1;
    reqs  = '1;
    base  = 0;
    for (int i = 0; i < N; i++) begin
      off[i]  = i * 10;
      lens[i] = 0;
    end
    apply();
    #3;
    checks++;
    if (bus.grants_o !== '0) begin
      errors++;
      $display("FAIL reset_grants got %b exp %b", bus.grants_o, 5'b0);
    end
    checks++;
    if (bus.locked_o !== 1'b0 || bus.starve_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got locked=%b starve=%b exp 0 0", bus.locked_o, bus.starve_o);
    end
    checks++;
    if (bus.owner_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_owner got %0d exp 0", bus.owner_o);
    end
    tick();
    rst_n = 1'b1;
    reqs  = '0;
    apply();
  endtask

  task automatic test_age();
    tick();
    ready = 1'b1;
    reqs  = 5'b10110;
    base  = 0;
    off[1] = 40; off[2] = 12; off[4] = 30;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00100) begin
      errors++;
      $display("FAIL age_grant got %b exp %b", bus.grants_o, 5'b00100);
    end
    tick();
    reqs = '0;
    apply();
    #1;
    checks++;
    if (bus.owner_o !== 3'd2) begin
      errors++;
      $display("FAIL age_owner got %0d exp 2", bus.owner_o);
    end
  endtask

  task automatic test_wrap();
    tick();
    base   = 250;
    off[0] = 0;
    off[3] = 10;
    reqs   = 5'b01001;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00001) begin
      errors++;
      $display("FAIL wrap_grant got %b exp %b", bus.grants_o, 5'b00001);
    end
    tick();
    reqs = '0;
    apply();
  endtask

  task automatic test_wormhole();
    tick();
    base    = 0;
    off[0]  = 0;
    off[1]  = 50;
    lens[1] = 3;
    reqs    = 5'b00010;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00010) begin
      errors++;
      $display("FAIL wh_header got %b exp %b", bus.grants_o, 5'b00010);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      reqs    = 5'b00011;
      lens[1] = $urandom_range(0, 15);
      apply();
      #1;
      checks++;
      if (bus.grants_o !== 5'b00010 || bus.locked_o !== 1'b1) begin
        errors++;
        $display("FAIL wh_body%0d got grants=%b locked=%b exp 00010 1", k, bus.grants_o,
                 bus.locked_o);
      end
    end
    tick();
    lens[1] = 0;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00001 || bus.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL wh_release got grants=%b locked=%b exp 00001 0", bus.grants_o,
               bus.locked_o);
    end
    tick();
    reqs = '0;
    apply();
  endtask

  task automatic test_stall_drop();
    tick();
    off[0]  = 0;
    off[2]  = 60;
    lens[2] = 2;
    reqs    = 5'b00100;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00100) begin
      errors++;
      $display("FAIL sd_header got %b exp %b", bus.grants_o, 5'b00100);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      ready = (k == 2);
      reqs  = (k == 2) ? 5'b00001 : 5'b00101;
      apply();
      #1;
      checks++;
      if (bus.grants_o !== '0 || bus.locked_o !== 1'b1) begin
        errors++;
        $display("FAIL sd_hold%0d got grants=%b locked=%b exp 00000 1", k, bus.grants_o,
                 bus.locked_o);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      reqs = 5'b00101;
      apply();
      #1;
      checks++;
      if (bus.grants_o !== 5'b00100 || bus.locked_o !== 1'b1) begin
        errors++;
        $display("FAIL sd_body%0d got grants=%b locked=%b exp 00100 1", k, bus.grants_o,
                 bus.locked_o);
      end
    end
    tick();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00001 || bus.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL sd_after got grants=%b locked=%b exp 00001 0", bus.grants_o, bus.locked_o);
    end
    tick();
    reqs = '0;
    lens[2] = 0;
    apply();
  endtask

  task automatic test_async_reset();
    tick();
    off[3]  = 30;
    off[1]  = 0;
    lens[3] = 3;
    reqs    = 5'b01000;
    apply();
    tick();
    reqs = 5'b01010;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b01000) begin
      errors++;
      $display("FAIL ar_body got %b exp %b", bus.grants_o, 5'b01000);
    end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.grants_o !== '0 || bus.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL ar_during got grants=%b locked=%b exp 00000 0", bus.grants_o,
               bus.locked_o);
    end
    #1;
    rst_n   = 1'b1;
    lens[3] = 0;
    apply();
    #1;
    checks++;
    if (bus.grants_o !== 5'b00010) begin
      errors++;
      $display("FAIL ar_after got %b exp %b", bus.grants_o, 5'b00010);
    end
    tick();
    reqs = '0;
    apply();
    #1;
    checks++;
    if (bus.owner_o !== 3'd1 || bus.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL ar_owner got owner=%0d locked=%b exp 1 0", bus.owner_o, bus.locked_o);
    end
  endtask

  task automatic test_starve();
    logic [N-1:0] exp_g;
    logic         exp_s;
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    off[0] = 0;
    off[4] = 80;
    for (int i = 0; i < N; i++) lens[i] = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      reqs = 5'b10001;
      apply();
      #1;
`ifdef BSG_MESH_AGE_SCHED_STARVE_EN
      exp_g = (k == 3) ? 5'b10000 : 5'b00001;
      exp_s = (k == 3);
`else
      exp_g = 5'b00001;
      exp_s = 1'b0;
`endif
      checks++;
      if (bus.grants_o !== exp_g || bus.starve_o !== exp_s) begin
        errors++;
        $display("FAIL starve%0d got grants=%b starve=%b exp %b %b", k, bus.grants_o,
                 bus.starve_o, exp_g, exp_s);
      end
    end
    tick();
    reqs = '0;
    apply();
  endtask

  task automatic test_random();
    int g;
    bit f;
    int r;
    for (int c = 0; c < 600; c++) begin
      tick();
      ready = ($urandom_range(0, 3) != 0);
      reqs  = N'($urandom);
      base  = $urandom_range(0, 255);
      for (int i = 0; i < N; i++) begin
        off[i] = 25 * $urandom_range(0, 4);
        r      = $urandom_range(0, 9);
        lens[i] = (r < 6) ? 0 : (r == 9) ? 15 : $urandom_range(1, 14);
      end
      apply();
      #1;
      g = model_pick(f);
      checks++;
      if (bus.grants_o !== onehot(g) || bus.starve_o !== f) begin
        errors++;
        $display("FAIL rand_grant c=%0d got grants=%b starve=%b exp %b %b", c, bus.grants_o,
                 bus.starve_o, onehot(g), f);
      end
      checks++;
      if (bus.locked_o !== m_locked || bus.owner_o !== 3'(m_owner)) begin
        errors++;
        $display("FAIL rand_state c=%0d got locked=%b owner=%0d exp %b %0d", c, bus.locked_o,
                 bus.owner_o, m_locked, m_owner);
      end
    end
  endtask

  initial begin
    test_reset();
    test_age();
    test_wrap();
    test_wormhole();
    test_stall_drop();
    test_async_reset();
    test_starve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
